// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Instruction-memory request/response bus between the fetch unit
//             and the instruction memory.
//  Signals  : imem_req    - request valid (held until imem_ack)
//             imem_addr   - request word address (held until imem_ack)
//             imem_ack    - request accepted this cycle
//             imem_rvalid - read data valid, at least one cycle after ack
//             imem_rdata  - instruction word
//  Modports : master (fetch unit side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch front end. Issues one outstanding request at a
//             time to instruction memory, buffers returned words with their PC
//             in a 4-entry FIFO and presents the FIFO head to the datapath.
//             A taken branch (PCSrcE) flushes the FIFO, redirects fetch and
//             discards any response already in flight.
//  Ports    : clk         - clock, rising edge
//             reset       - asynchronous reset, active low
//             StallF      - hold the current head instruction
//             PCSrcE      - redirect request from Execute
//             PCTargetE   - redirect target (word aligned internally)
//             imem        - instruction memory bus (master side)
//             InstrF      - head instruction (NOP when empty)
//             PCF         - PC of head instruction (fetch PC when empty)
//             InstrValidF - head entry valid
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        StallF,
    input  wire logic        PCSrcE,
    input  wire logic [31:0] PCTargetE,
    fetch_unit_if.master     imem,
    output logic      [31:0] InstrF,
    output logic      [31:0] PCF,
    output logic             InstrValidF
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    // D-states track a transaction whose response must be thrown away
    // because a redirect arrived after it was issued.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DREQ  = 3'd3,
        S_DWAIT = 3'd4
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic [31:0] req_addr_q;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] fifo_pc_q    [4];
    logic [31:0] fifo_instr_q [4];

    logic [31:0] w_target;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;

    assign w_target = {PCTargetE[31:2], 2'b00};
    // A response coinciding with a redirect belongs to the old path.
    assign w_push   = (state_q == S_WAIT) && imem.imem_rvalid && !PCSrcE;
    assign w_pop    = InstrValidF && !StallF && !PCSrcE;
    // In the D-states the FIFO is already empty; only fetch_pc reloads.
    assign w_flush  = PCSrcE && ((state_q == S_IDLE) || (state_q == S_REQ) ||
                                 (state_q == S_WAIT));

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr_q;

    assign InstrValidF = (count_q != 3'd0);
    assign InstrF      = InstrValidF ? fifo_instr_q[rd_ptr_q] : c_NOP;
    assign PCF         = InstrValidF ? fifo_pc_q[rd_ptr_q]    : fetch_pc_q;

    // Request FSM with registered bus outputs. The address is captured on
    // entry to REQ so it stays stable even if fetch_pc is redirected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            req_addr_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!PCSrcE && (count_q != 3'd4)) begin
                        state_q    <= S_REQ;
                        req_q      <= 1'b1;
                        req_addr_q <= fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (imem.imem_ack) begin
                        // Accepted in the same cycle as a redirect: the
                        // response is already stale.
                        req_q   <= 1'b0;
                        state_q <= PCSrcE ? S_DWAIT : S_WAIT;
                    end else if (PCSrcE) begin
                        state_q <= S_DREQ;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_q <= S_IDLE;
                    end else if (PCSrcE) begin
                        state_q <= S_DWAIT;
                    end
                end
                S_DREQ: begin
                    if (imem.imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_DWAIT;
                    end
                end
                S_DWAIT: begin
                    if (imem.imem_rvalid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (PCSrcE) begin
            fetch_pc_d = w_target;
        end else if (w_push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (w_flush) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= 32'h0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count_q says valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem.imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A cycle-level memory model
//             answers requests; returned words are pushed to a scoreboard
//             queue and compared against the DUT head as it is consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        InstrValidF;

    fetch_unit_if u_if ();

    fetch_unit u_dut (
        .clk         (clk),
        .reset       (reset),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem        (u_if.master),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .InstrValidF (InstrValidF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus controls, applied at the next negedge by cyc().
    logic        stall_v;
    logic        pcsrc_v;
    logic [31:0] tgt_v;
    bit          ack_en;
    int          rv_delay;
    bit          stray_rv;

    // Memory / reference model state.
    entry_t      sb_q[$];
    logic [31:0] exp_pc;
    bit          mem_busy;
    int          rv_cnt;
    logic [31:0] pend_addr;
    bit          drop;
    bit          req_seen;
    logic [31:0] req_first;
    bit          prev_pcsrc;
    bit          prev_pop;
    bit          prev_push;
    logic [31:0] prev_tgt;
    entry_t      prev_ent;

    function automatic logic [31:0] memw(input logic [31:0] a);
        case (a)
            32'h0000_0000: memw = 32'h0070_0093;
            32'h0000_0004: memw = 32'h0030_0113;
            32'h0000_0008: memw = 32'h0020_81B3;
            default:       memw = (a * 32'd3) ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle the model for the previous edge, compare the
    // DUT outputs, then drive this cycle's inputs and memory response.
    task automatic cyc();
        @(negedge clk);
        if (prev_pcsrc) begin
            sb_q.delete();
            exp_pc = {prev_tgt[31:2], 2'b00};
        end else begin
            if (prev_pop) void'(sb_q.pop_front());
            if (prev_push) begin
                sb_q.push_back(prev_ent);
                exp_pc = exp_pc + 32'd4;
            end
        end

        chk("valid", 32'(InstrValidF), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("head_instr", InstrF, sb_q[0].instr);
            chk("head_pc", PCF, sb_q[0].pc);
        end else begin
            chk("empty_nop", InstrF, c_NOP);
            chk("empty_pcf", PCF, exp_pc);
        end
        if (sb_q.size() == 4 && !mem_busy) chk("full_noreq", 32'(u_if.imem_req), 32'd0);

        StallF    = stall_v;
        PCSrcE    = pcsrc_v;
        PCTargetE = tgt_v;
        u_if.imem_ack    = 1'b0;
        u_if.imem_rvalid = 1'b0;
        prev_push = 1'b0;
        if (stray_rv) begin
            u_if.imem_rvalid = 1'b1;
            u_if.imem_rdata  = 32'hDEAD_BEEF;
        end else if (mem_busy) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                u_if.imem_rvalid = 1'b1;
                u_if.imem_rdata  = memw(pend_addr);
                if (!drop && !pcsrc_v) begin
                    prev_push = 1'b1;
                    prev_ent  = '{pc: pend_addr, instr: memw(pend_addr)};
                end
                mem_busy = 1'b0;
                drop     = 1'b0;
            end
        end else if (u_if.imem_req) begin
            if (!req_seen) begin
                req_seen  = 1'b1;
                req_first = u_if.imem_addr;
                chk("req_addr", u_if.imem_addr, exp_pc);
            end else begin
                chk("req_stable", u_if.imem_addr, req_first);
            end
            if (ack_en) begin
                u_if.imem_ack = 1'b1;
                pend_addr = u_if.imem_addr;
                mem_busy  = 1'b1;
                rv_cnt    = rv_delay;
                req_seen  = 1'b0;
            end
        end
        if (pcsrc_v && (u_if.imem_req || mem_busy)) drop = 1'b1;

        prev_pop   = (sb_q.size() != 0) && !stall_v && !pcsrc_v;
        prev_pcsrc = pcsrc_v;
        prev_tgt   = tgt_v;
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b0;
        sb_q.delete();
        exp_pc     = 32'h0;
        mem_busy   = 1'b0;
        drop       = 1'b0;
        req_seen   = 1'b0;
        prev_pcsrc = 1'b0;
        prev_pop   = 1'b0;
        prev_push  = 1'b0;
        repeat (n) begin
            cyc();
            chk("rst_req", 32'(u_if.imem_req), 32'd0);
            chk("rst_addr", u_if.imem_addr, 32'h0);
            chk("rst_pcf", PCF, 32'h0);
        end
        reset = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] exp, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (u_if.imem_req) found = 1'b1;
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        if (found) chk(tag, u_if.imem_addr, exp);
    endtask

    task automatic wait_busy();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (mem_busy) found = 1'b1;
        end
        chk("wait_ack_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_noreq();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (!u_if.imem_req) found = 1'b1;
        end
        chk("req_drop_seen", 32'(found), 32'd1);
    endtask

    initial begin
        logic [31:0] old_addr;
        reset = 1'b1;
        StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        u_if.imem_ack = 1'b0; u_if.imem_rvalid = 1'b0; u_if.imem_rdata = 32'h0;
        stall_v = 1'b0; pcsrc_v = 1'b0; tgt_v = 32'h0;
        ack_en = 1'b1; rv_delay = 1; stray_rv = 1'b0;
        #1;
        do_reset(3);

        // Sequential fetch from address 0.
        wait_req(32'h0, "first_req");
        repeat (12) cyc();

        // Fill the FIFO while stalled, then drain and refill.
        stall_v = 1'b1;
        repeat (30) cyc();
        chk("full_req", 32'(u_if.imem_req), 32'd0);
        chk("full_valid", 32'(InstrValidF), 32'd1);
        stall_v = 1'b0;
        repeat (20) cyc();

        // Redirect while waiting for read data.
        rv_delay = 3;
        wait_busy();
        pcsrc_v = 1'b1; tgt_v = 32'h0000_0100;
        cyc();
        pcsrc_v = 1'b0;
        cyc();
        chk("wait_flush_empty", 32'(InstrValidF), 32'd0);
        wait_req(32'h0000_0100, "wait_branch_addr");
        rv_delay = 1;
        repeat (10) cyc();

        // Redirect while the request is still unacknowledged.
        ack_en = 1'b0;
        for (int i = 0; i < 40 && !u_if.imem_req; i++) cyc();
        old_addr = u_if.imem_addr;
        pcsrc_v = 1'b1; tgt_v = 32'h0000_0100;
        cyc();
        pcsrc_v = 1'b0;
        repeat (3) cyc();
        chk("dreq_req", 32'(u_if.imem_req), 32'd1);
        chk("dreq_hold", u_if.imem_addr, old_addr);
        ack_en = 1'b1;
        wait_noreq();
        wait_req(32'h0000_0100, "req_branch_addr");
        repeat (8) cyc();

        // Misaligned redirect target.
        ack_en = 1'b0;
        repeat (2) cyc();
        pcsrc_v = 1'b1; tgt_v = 32'h0000_0103;
        cyc();
        pcsrc_v = 1'b0;
        ack_en = 1'b1;
        wait_noreq();
        wait_req(32'h0000_0100, "misaligned_addr");
        repeat (8) cyc();

        // Reset in the middle of a transaction, followed by a stray rvalid.
        rv_delay = 4;
        wait_busy();
        cyc();
        stray_rv = 1'b1;
        do_reset(2);
        cyc();
        stray_rv = 1'b0;
        rv_delay = 1;
        wait_req(32'h0, "post_reset_req");
        repeat (10) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL expose: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL expose: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL expose: StallF  in  1  hazard stall; 1 holds the current head instruction.
REQ-004 SHALL expose: PCSrcE  in  1  taken branch/jump resolved in Execute; flush and redirect.
REQ-005 SHALL expose: PCTargetE  in  32  redirect target, sampled when PCSrcE=1.
REQ-006 SHALL expose: imem_req  out  1  instruction memory request valid.
REQ-007 SHALL expose: imem_addr  out  32  request word address.
REQ-008 SHALL expose: imem_ack  in  1  request accepted this cycle.
REQ-009 SHALL expose: imem_rvalid  in  1  read data valid; arrives at least 1 cycle after ack.
REQ-010 SHALL expose: imem_rdata  in  32  instruction word.
REQ-011 SHALL expose: InstrF  out  32  head instruction to the datapath.
REQ-012 SHALL expose: PCF  out  32  PC of the head instruction.
REQ-013 SHALL expose: InstrValidF  out  1  head entry valid.

Function
REQ-014 SHALL hold fetch_pc (next address to request) and a 4-entry FIFO of {pc[31:0], instr[31:0]}.
REQ-015 SHALL allow at most one outstanding memory transaction.
REQ-016 SHALL implement states IDLE, REQ, WAIT, DREQ, DWAIT.
REQ-017 IDLE: if FIFO count < 4 and PCSrcE=0, go to REQ; imem_req=0.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc; on imem_ack go to WAIT.
REQ-019 imem_req and imem_addr SHALL stay stable from assertion until imem_ack.
REQ-020 WAIT: on imem_rvalid, push {fetch_pc, imem_rdata}, set fetch_pc += 4 (mod 2^32), go to IDLE.
REQ-021 PCSrcE=1 in IDLE or WAIT SHALL clear the FIFO and load fetch_pc = {PCTargetE[31:2], 2'b00}.
REQ-022 After PCSrcE=1, IDLE SHALL stay IDLE; WAIT SHALL go to DWAIT.
REQ-023 PCSrcE=1 in REQ SHALL clear the FIFO, load fetch_pc, and go to DREQ (request still held).
REQ-024 DREQ: imem_req=1 with the old address; on imem_ack go to DWAIT.
REQ-025 DWAIT: on imem_rvalid, discard data without pushing; go to IDLE.
REQ-026 PCSrcE in DREQ/DWAIT SHALL reload fetch_pc only; the state is unchanged.
REQ-027 imem_rvalid coincident with PCSrcE=1 in WAIT SHALL be discarded; state goes to IDLE.
REQ-028 imem_rvalid in IDLE/REQ/DREQ SHALL be ignored.
REQ-029 Head pop SHALL occur when InstrValidF=1, StallF=0 and PCSrcE=0.
REQ-030 Simultaneous push and pop SHALL leave the count unchanged; FIFO pointers SHALL wrap mod 4.
REQ-031 Output is the FIFO head, combinationally: InstrValidF = (count != 0).
REQ-032 When empty, InstrF SHALL be 0x00000013 (NOP) and PCF SHALL be the current fetch_pc.
REQ-033 A pushed entry SHALL be visible on InstrF the cycle after imem_rvalid (1-cycle latency).
REQ-034 Count SHALL never exceed 4; no request is issued while count = 4.

Reset
REQ-035 reset=0 SHALL asynchronously set: state IDLE, fetch_pc 0x00000000, FIFO empty, imem_req 0.
REQ-036 During reset, outputs SHALL be: InstrF 0x00000013, PCF 0x00000000, InstrValidF 0, imem_addr 0x00000000.
REQ-037 Reset asserted mid-transaction SHALL abandon it; a later stray rvalid lands in IDLE and is ignored.
REQ-038 The first request SHALL be issued 1 cycle after reset deasserts (state REQ at second edge).

Verification
REQ-039 Sequential fetch: memory returns 0x00700093, 0x00300113, 0x002081B3; ack same cycle, rvalid next -> PCF 0,4,8 with matching InstrF, InstrValidF=1.
REQ-040 Full FIFO: StallF=1, 4 words fetched -> count 4, imem_req=0; release StallF -> one pop per cycle, refill resumes.
REQ-041 Branch in WAIT: PCSrcE=1, PCTargetE=0x00000100 -> in-flight data dropped, FIFO empty, next imem_addr=0x00000100.
REQ-042 Branch in REQ without ack: imem_addr held at old value until ack, response dropped, then request 0x00000100.
REQ-043 Misaligned target 0x00000103 -> next imem_addr=0x00000100.
REQ-044 Reset mid-WAIT: reset=0 then stray rvalid -> FIFO empty, PCF=0, first post-reset request to 0x00000000.
